stage4_lane_arbiter: RTL and testbench

Round-robin scheduler that shares the single stage-4 message output path among three message lanes. Each lane presents a message beat with its N_type_control and message_mux_control fields through a valid/ready handshake. The block buffers one beat per lane and grants the output register to one lane per cycle. A lane whose multi-beat message is in progress locks the grant until its last beat. It sits between the three stage-3 lane producers and the downstream stage-4 pipeline register.

---
 rtl/stage4_lane_arbiter.sv | 121 ++++++++++++
 tb/tb_stage4_lane_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage4_lane_arbiter.sv
// rtl/stage4_lane_arbiter.sv - round-robin arbiter sharing the stage-4 message path among three lanes
module stage4_lane_arbiter #(
  parameter int MSG_BITS = 64,
  parameter int NT_W     = 3,
  parameter int MC_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            in_valid,
  output logic [2:0]            in_ready,
  input  logic [2:0]            in_last,
  input  logic [3*MSG_BITS-1:0] message_in,
  input  logic [3*NT_W-1:0]     N_type_control_in,
  input  logic [3*MC_W-1:0]     message_mux_control_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MSG_BITS-1:0]   out_message,
  output logic [NT_W-1:0]       out_N_type_control,
  output logic [MC_W-1:0]       out_message_mux_control,
  output logic [1:0]            out_lane,
  output logic                  out_last
);

  typedef enum logic {ARB, LOCK} state_t;

  state_t              state;
  logic [1:0]          lock_lane;
  logic [1:0]          rr_ptr;
  logic [2:0]          hold_valid;
  logic [2:0]          hold_last;
  logic [MSG_BITS-1:0] hold_data [3];
  logic [NT_W-1:0]     hold_nt   [3];
  logic [MC_W-1:0]     hold_mc   [3];

  logic       slot_free;
  logic [2:0] accept;
  logic       grant_valid;
  logic [1:0] grant;
  logic [1:0] cand;

  function automatic logic [1:0] lane_inc(input logic [1:0] l);
    return (l == 2'd2) ? 2'd0 : l + 2'd1;
  endfunction

  // in_ready depends only on registered state so producers see no combinational path
  assign in_ready  = ~hold_valid & {3{~rst}};
  assign slot_free = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready;

  always_comb begin
    grant_valid = 1'b0;
    grant       = 2'd0;
    cand        = rr_ptr;
    if (state == LOCK) begin
      grant       = lock_lane;
      grant_valid = hold_valid[lock_lane];
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!grant_valid && hold_valid[cand]) begin
          grant_valid = 1'b1;
          grant       = cand;
        end
        cand = lane_inc(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                   <= ARB;
      lock_lane               <= 2'd0;
      rr_ptr                  <= 2'd0;
      hold_valid              <= 3'b000;
      hold_last               <= 3'b000;
      out_valid               <= 1'b0;
      out_message             <= '0;
      out_N_type_control      <= '0;
      out_message_mux_control <= '0;
      out_lane                <= 2'd0;
      out_last                <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        hold_data[k] <= '0;
        hold_nt[k]   <= '0;
        hold_mc[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (accept[k]) begin
          hold_valid[k] <= 1'b1;
          hold_last[k]  <= in_last[k];
          hold_data[k]  <= message_in[k*MSG_BITS +: MSG_BITS];
          hold_nt[k]    <= N_type_control_in[k*NT_W +: NT_W];
          hold_mc[k]    <= message_mux_control_in[k*MC_W +: MC_W];
        end
      end
      if (slot_free) begin
        if (grant_valid) begin
          out_valid               <= 1'b1;
          out_message             <= hold_data[grant];
          out_N_type_control      <= hold_nt[grant];
          out_message_mux_control <= hold_mc[grant];
          out_lane                <= grant;
          out_last                <= hold_last[grant];
          hold_valid[grant]       <= 1'b0;
          // rr_ptr only advances on arbitrated grants, not while a message holds the lock
          if (state == ARB)
            rr_ptr <= lane_inc(grant);
          if (hold_last[grant]) begin
            state <= ARB;
          end else begin
            state     <= LOCK;
            lock_lane <= grant;
          end
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_stage4_lane_arbiter.sv
// tb/tb_stage4_lane_arbiter.sv - directed and randomized checks of stage4_lane_arbiter against a queue-based model
module tb_stage4_lane_arbiter;
  localparam int MSG_BITS = 64;
  localparam int NT_W     = 3;
  localparam int MC_W     = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [2:0]            in_valid;
  logic [2:0]            in_ready;
  logic [2:0]            in_last;
  logic [3*MSG_BITS-1:0] message_in;
  logic [3*NT_W-1:0]     nt_in;
  logic [3*MC_W-1:0]     mc_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [MSG_BITS-1:0]   out_message;
  logic [NT_W-1:0]       out_nt;
  logic [MC_W-1:0]       out_mc;
  logic [1:0]            out_lane;
  logic                  out_last;

  always #5 clk = ~clk;

  stage4_lane_arbiter #(.MSG_BITS(MSG_BITS), .NT_W(NT_W), .MC_W(MC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .message_in(message_in), .N_type_control_in(nt_in), .message_mux_control_in(mc_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_message(out_message),
    .out_N_type_control(out_nt), .out_message_mux_control(out_mc),
    .out_lane(out_lane), .out_last(out_last)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  nt;
    logic [3:0]  mc;
    logic        last;
  } beat_t;

  typedef struct {
    int    lane;
    beat_t b;
    int    cyc;
  } log_t;

  beat_t lane_q [3][$];
  beat_t sent   [3][$];
  log_t  out_log[$];

  // reference model: one buffered beat per lane, one output slot, lock = -1 when free
  bit    mh_valid [3];
  beat_t mh       [3];
  bit    mo_valid;
  beat_t mo;
  int    mo_lane;
  int    m_rr;
  int    m_lock;
  int    cyc;
  int    checks;
  int    failures;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input int lane, input logic [63:0] data, input logic last);
    beat_t b;
    b.data = data;
    b.nt   = 3'($urandom);
    b.mc   = 4'($urandom);
    b.last = last;
    lane_q[lane].push_back(b);
    sent[lane].push_back(b);
  endtask

  task automatic cycle(input logic r, input logic ordy, input logic [2:0] gate);
    bit          cap [3];
    int          g;
    bit          free;
    logic [2:0]  exp_ready;
    rst       = r;
    out_ready = ordy;
    for (int k = 0; k < 3; k++) begin
      if (gate[k] && lane_q[k].size() > 0) begin
        in_valid[k]                  = 1'b1;
        message_in[k*MSG_BITS +: 64] = lane_q[k][0].data;
        nt_in[k*NT_W +: NT_W]        = lane_q[k][0].nt;
        mc_in[k*MC_W +: MC_W]        = lane_q[k][0].mc;
        in_last[k]                   = lane_q[k][0].last;
      end else begin
        in_valid[k]                  = 1'b0;
        message_in[k*MSG_BITS +: 64] = {$urandom, $urandom};
        nt_in[k*NT_W +: NT_W]        = 3'($urandom);
        mc_in[k*MC_W +: MC_W]        = 4'($urandom);
        in_last[k]                   = 1'($urandom);
      end
    end
    if (r) begin
      for (int k = 0; k < 3; k++) begin
        mh_valid[k] = 0;
        mh[k]       = '0;
      end
      mo_valid = 0;
      mo       = '0;
      mo_lane  = 0;
      m_rr     = 0;
      m_lock   = -1;
    end else begin
      free = !mo_valid || ordy;
      g    = -1;
      if (free) begin
        if (m_lock >= 0) begin
          if (mh_valid[m_lock]) g = m_lock;
        end else begin
          for (int i = 0; i < 3; i++)
            if (g < 0 && mh_valid[(m_rr + i) % 3]) g = (m_rr + i) % 3;
        end
      end
      for (int k = 0; k < 3; k++) cap[k] = in_valid[k] && !mh_valid[k];
      if (mo_valid && ordy) out_log.push_back('{mo_lane, mo, cyc});
      if (free) begin
        if (g >= 0) begin
          mo          = mh[g];
          mo_lane     = g;
          mo_valid    = 1;
          mh_valid[g] = 0;
          if (m_lock < 0) m_rr = (g + 1) % 3;
          m_lock = mh[g].last ? -1 : g;
        end else begin
          mo_valid = 0;
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (cap[k]) begin
          mh[k]       = lane_q[k].pop_front();
          mh_valid[k] = 1;
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int k = 0; k < 3; k++) exp_ready[k] = !r && !mh_valid[k];
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("out_valid", 64'(out_valid), 64'(mo_valid));
    chk("out_message", out_message, mo.data);
    chk("out_nt", 64'(out_nt), 64'(mo.nt));
    chk("out_mc", 64'(out_mc), 64'(mo.mc));
    chk("out_lane", 64'(out_lane), 64'(mo_lane));
    chk("out_last", 64'(out_last), 64'(mo.last));
  endtask

  task automatic run(input int n, input logic ordy, input logic [2:0] gate);
    for (int i = 0; i < n; i++) cycle(1'b0, ordy, gate);
  endtask

  task automatic do_reset();
    for (int k = 0; k < 3; k++) begin
      lane_q[k].delete();
      sent[k].delete();
    end
    cycle(1'b1, 1'b0, 3'b000);
    cycle(1'b1, 1'b0, 3'b000);
    out_log.delete();
  endtask

  logic [63:0] snap;
  int          idx [3];

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    in_valid  = 3'b000;
    in_last   = 3'b000;
    message_in = '0;
    nt_in     = '0;
    mc_in     = '0;
    out_ready = 1'b0;
    rst       = 1'b1;

    // reset then idle
    do_reset();
    chk("reset_in_ready", 64'(in_ready), 64'h0);
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    run(1, 1'b1, 3'b111);
    chk("idle_in_ready", 64'(in_ready), 64'h7);
    chk("idle_out_valid", 64'(out_valid), 64'h0);

    // round-robin fairness
    do_reset();
    for (int i = 0; i < 12; i++)
      for (int k = 0; k < 3; k++) push_beat(k, {$urandom, $urandom}, 1'b1);
    run(45, 1'b1, 3'b111);
    chk("rr_count", 64'(out_log.size()), 64'd36);
    for (int i = 0; i < out_log.size(); i++)
      chk("rr_lane", 64'(out_log[i].lane), 64'(i % 3));

    // lock on lane 1 with lanes 0 and 2 waiting; rr_ptr first moved to 1
    do_reset();
    push_beat(0, 64'h55, 1'b1);
    run(5, 1'b1, 3'b111);
    out_log.delete();
    push_beat(0, 64'hB0, 1'b1);
    push_beat(1, 64'hA1, 1'b0);
    push_beat(1, 64'hA2, 1'b0);
    push_beat(1, 64'hA3, 1'b1);
    push_beat(2, 64'hC0, 1'b1);
    run(15, 1'b1, 3'b111);
    chk("lock_count", 64'(out_log.size()), 64'd5);
    if (out_log.size() == 5) begin
      chk("lock_lane0", 64'(out_log[0].lane), 64'd1);
      chk("lock_data0", out_log[0].b.data, 64'hA1);
      chk("lock_lane1", 64'(out_log[1].lane), 64'd1);
      chk("lock_data1", out_log[1].b.data, 64'hA2);
      chk("lock_lane2", 64'(out_log[2].lane), 64'd1);
      chk("lock_data2", out_log[2].b.data, 64'hA3);
      chk("lock_lane3", 64'(out_log[3].lane), 64'd2);
      chk("lock_data3", out_log[3].b.data, 64'hC0);
      chk("lock_lane4", 64'(out_log[4].lane), 64'd0);
      chk("lock_data4", out_log[4].b.data, 64'hB0);
    end

    // backpressure: everything fills, output holds, then drains intact
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) push_beat(k, {$urandom, $urandom}, 1'b1);
    run(3, 1'b0, 3'b111);
    chk("bp_in_ready_full", 64'(in_ready), 64'h0);
    chk("bp_out_valid", 64'(out_valid), 64'h1);
    snap = out_message;
    run(5, 1'b0, 3'b111);
    chk("bp_stable", out_message, snap);
    chk("bp_still_full", 64'(in_ready), 64'h0);
    run(40, 1'b1, 3'b111);
    chk("bp_count", 64'(out_log.size()), 64'd12);
    for (int k = 0; k < 3; k++) idx[k] = 0;
    for (int i = 0; i < out_log.size(); i++) begin
      if (idx[out_log[i].lane] < sent[out_log[i].lane].size())
        chk("bp_order", out_log[i].b.data, sent[out_log[i].lane][idx[out_log[i].lane]].data);
      idx[out_log[i].lane]++;
    end

    // reset while locked on lane 2 with other lanes buffered
    do_reset();
    push_beat(2, 64'hD0, 1'b0);
    push_beat(2, 64'hD1, 1'b0);
    push_beat(2, 64'hD2, 1'b1);
    run(2, 1'b1, 3'b100);
    push_beat(0, 64'hE0, 1'b1);
    push_beat(1, 64'hF0, 1'b1);
    run(2, 1'b0, 3'b111);
    chk("mid_lock_full", 64'(in_ready), 64'h0);
    for (int k = 0; k < 3; k++) lane_q[k].delete();
    cycle(1'b1, 1'b0, 3'b000);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    run(1, 1'b1, 3'b000);
    chk("rst_hold_clear", 64'(in_ready), 64'h7);
    chk("rst_out_idle", 64'(out_valid), 64'h0);
    out_log.delete();
    push_beat(0, 64'h10, 1'b1);
    push_beat(1, 64'h11, 1'b1);
    push_beat(2, 64'h12, 1'b1);
    run(8, 1'b1, 3'b111);
    chk("post_rst_count", 64'(out_log.size()), 64'd3);
    if (out_log.size() > 0) chk("post_rst_first", 64'(out_log[0].lane), 64'd0);

    // per-lane rate: lane 0 alone gives one beat every two cycles
    do_reset();
    for (int i = 0; i < 16; i++) push_beat(0, 64'(i + 256), 1'b1);
    run(40, 1'b1, 3'b001);
    chk("rate_count", 64'(out_log.size()), 64'd16);
    for (int i = 0; i < out_log.size(); i++) begin
      chk("rate_data", out_log[i].b.data, 64'(i + 256));
      if (i > 0) chk("rate_gap", 64'(out_log[i].cyc - out_log[i-1].cyc), 64'd2);
    end

    // randomized traffic with multi-beat messages, backpressure and occasional reset
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 3; k++)
        if (lane_q[k].size() < 3) push_beat(k, {$urandom, $urandom}, 1'($urandom));
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), 3'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
